// File: rtl/rx_serial_7o1_pkg.sv
// Shared definitions for the 7O1 serial receiver: frame geometry,
// FSM state encoding and the parity helper used when a frame is stored.
package rx_serial_7o1_pkg;

  localparam int FRAME_BITS = 9;  // 7 data + parity + stop, start handled separately
  localparam int DATA_BITS  = 7;

  typedef enum logic [2:0] {
    REPOUSO  = 3'd0,
    INICIO   = 3'd1,
    ESPERA   = 3'd2,
    AMOSTRA  = 3'd3,
    ARMAZENA = 3'd4,
    FINAL    = 3'd5
  } estado_t;

  // Odd parity holds when data bits plus the parity bit contain an odd count of ones.
  function automatic logic paridade_impar(input logic [DATA_BITS:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/rx_serial_7o1_uc.sv
// Control unit of the 7O1 receiver: state register plus next-state and
// decoded control strobes. Holds no datapath state of its own.
module rx_serial_7o1_uc
  import rx_serial_7o1_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_linha,
  input  logic i_linha_ant,
  input  logic i_fim_meio,
  input  logic i_fim_bit,
  input  logic i_ultimo_bit,
  output logic o_zera_tick,
  output logic o_zera_bit,
  output logic o_desloca,
  output logic o_conta_bit,
  output logic o_registra,
  output logic o_pronto,
  output logic o_em_recepcao
);

  estado_t r_estado;
  estado_t w_prox;

  // State register; reset returns to idle from anywhere, aborting a frame.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_estado <= REPOUSO;
    else         r_estado <= w_prox;
  end

  // Next-state and decoded strobes; the tick counter restarts on every state change.
  always_comb begin
    w_prox        = r_estado;
    o_zera_tick   = 1'b0;
    o_zera_bit    = 1'b0;
    o_desloca     = 1'b0;
    o_conta_bit   = 1'b0;
    o_registra    = 1'b0;
    o_pronto      = 1'b0;
    o_em_recepcao = (r_estado != REPOUSO);
    case (r_estado)
      REPOUSO: begin
        // Only a 1->0 transition starts a frame, so a line stuck low never restarts.
        if (i_linha_ant && !i_linha) w_prox = INICIO;
      end
      INICIO: begin
        if (i_fim_meio) begin
          if (!i_linha) begin
            w_prox     = ESPERA;
            o_zera_bit = 1'b1;
          end else begin
            w_prox = REPOUSO;  // start bit gone by mid-bit: treat as glitch
          end
        end
      end
      ESPERA: begin
        if (i_fim_bit) w_prox = AMOSTRA;
      end
      AMOSTRA: begin
        o_desloca   = 1'b1;
        o_conta_bit = 1'b1;
        w_prox      = i_ultimo_bit ? ARMAZENA : ESPERA;
      end
      ARMAZENA: begin
        o_registra = 1'b1;
        w_prox     = FINAL;
      end
      FINAL: begin
        o_pronto = 1'b1;
        w_prox   = REPOUSO;
      end
      default: w_prox = REPOUSO;
    endcase
    o_zera_tick = (w_prox != r_estado);
  end

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 UART receiver: 2-FF line synchronizer, mid-bit sampling counters,
// 9-bit LSB-first shift register and the output word/flag registers.
// ESPERA plus the one-cycle AMOSTRA span exactly one bit period, so the
// sample point does not drift across the frame.
module rx_serial_7o1
  import rx_serial_7o1_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dado_serial,
  input  logic                 recebe_dado,
  output logic [DATA_BITS-1:0] dados_ascii,
  output logic                 tem_dado,
  output logic                 pronto,
  output logic                 paridade_ok,
  output logic                 erro_stop,
  output logic                 sobreposicao,
  output logic                 em_recepcao
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int MEIO   = CLKS_PER_BIT / 2 - 2;  // last tick of INICIO
  localparam int FIM    = CLKS_PER_BIT - 2;      // last tick of ESPERA

  logic                  r_sinc1;
  logic                  r_linha;
  logic                  r_linha_ant;
  logic [TICK_W-1:0]     r_tick;
  logic [3:0]            r_bit;
  logic [FRAME_BITS-1:0] r_desl;
  logic [DATA_BITS-1:0]  r_dados;
  logic                  r_tem;
  logic                  r_par_ok;
  logic                  r_erro_stop;
  logic                  r_sobre;

  logic w_zera_tick;
  logic w_zera_bit;
  logic w_desloca;
  logic w_conta_bit;
  logic w_registra;
  logic w_fim_meio;
  logic w_fim_bit;
  logic w_ultimo_bit;

  assign w_fim_meio   = (r_tick == TICK_W'(MEIO));
  assign w_fim_bit    = (r_tick == TICK_W'(FIM));
  assign w_ultimo_bit = (r_bit == 4'(FRAME_BITS - 1));

  rx_serial_7o1_uc u_uc (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_linha       (r_linha),
    .i_linha_ant   (r_linha_ant),
    .i_fim_meio    (w_fim_meio),
    .i_fim_bit     (w_fim_bit),
    .i_ultimo_bit  (w_ultimo_bit),
    .o_zera_tick   (w_zera_tick),
    .o_zera_bit    (w_zera_bit),
    .o_desloca     (w_desloca),
    .o_conta_bit   (w_conta_bit),
    .o_registra    (w_registra),
    .o_pronto      (pronto),
    .o_em_recepcao (em_recepcao)
  );

  // Synchronizer and edge history, preset to idle-high so reset never fakes a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sinc1     <= 1'b1;
      r_linha     <= 1'b1;
      r_linha_ant <= 1'b1;
    end else begin
      r_sinc1     <= dado_serial;
      r_linha     <= r_sinc1;
      r_linha_ant <= r_linha;
    end
  end

  // Tick counter measures time spent in the current state.
  always_ff @(posedge clock) begin
    if (reset || w_zera_tick) r_tick <= '0;
    else                      r_tick <= r_tick + TICK_W'(1);
  end

  // Bit counter indexes data, parity and stop samples 0..8.
  always_ff @(posedge clock) begin
    if (reset || w_zera_bit) r_bit <= '0;
    else if (w_conta_bit)    r_bit <= r_bit + 4'd1;
  end

  // Shift in from the top so the LSB-first stream lands in natural bit order.
  always_ff @(posedge clock) begin
    if (reset)          r_desl <= '0;
    else if (w_desloca) r_desl <= {r_linha, r_desl[FRAME_BITS-1:1]};
  end

  // Output word and flags; storing a frame takes priority over the acknowledge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dados     <= '0;
      r_tem       <= 1'b0;
      r_par_ok    <= 1'b0;
      r_erro_stop <= 1'b0;
      r_sobre     <= 1'b0;
    end else if (w_registra) begin
      r_dados     <= r_desl[DATA_BITS-1:0];
      r_par_ok    <= paridade_impar(r_desl[DATA_BITS:0]);
      r_erro_stop <= ~r_desl[FRAME_BITS-1];
      r_tem       <= 1'b1;
      if (recebe_dado)  r_sobre <= 1'b0;
      else if (r_tem)   r_sobre <= 1'b1;
    end else if (recebe_dado) begin
      r_tem   <= 1'b0;
      r_sobre <= 1'b0;
    end
  end

  assign dados_ascii  = r_dados;
  assign tem_dado     = r_tem;
  assign paridade_ok  = r_par_ok;
  assign erro_stop    = r_erro_stop;
  assign sobreposicao = r_sobre;

endmodule
